// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction prefetch buffer between the program counter and the
//            program memory. Issues at most one memory transaction at a time,
//            buffers up to two {address, instruction} pairs for decode, and
//            discards buffered and in-flight fetches on a taken branch/jump.
// Ports    : clk, rst_n              - clock, asynchronous active-low reset
//            fetch_req_i/addr_i      - fetch request/address from the PC
//            fetch_gnt_o             - grant to the PC (PC advances on it)
//            instr_req_o/addr_o      - program-memory request/address
//            instr_gnt_i/rvalid_i    - program-memory grant/read-data valid
//            instr_rdata_i           - program-memory read data
//            flush_i                 - discard everything buffered/in flight
//            id_valid_o/instr_o/pc_o - head entry presented to decode
//            id_ready_i              - decode accepts the head entry
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                      fetch_gnt_o,
    output logic                      instr_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                      instr_gnt_i,
    input  logic                      instr_rvalid_i,
    input  logic [31:0]               instr_rdata_i,
    input  logic                      flush_i,
    output logic                      id_valid_o,
    output logic [31:0]               id_instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] id_pc_o,
    input  logic                      id_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_GNT    = 2'd1,
        S_WAIT_RVALID = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic                        discard_q, discard_d;
    logic [MEM_ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;   // held while waiting for grant
    logic [MEM_ADDR_WIDTH-1:0]   gnt_addr_q, gnt_addr_d;   // address of the outstanding response
    logic [1:0]                  count_q, count_d;
    logic [MEM_ADDR_WIDTH-1:0]   e0_addr_q, e0_addr_d, e1_addr_q, e1_addr_d;
    logic [31:0]                 e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;

    logic       pop;
    logic       inflight;
    logic [2:0] occupancy;
    logic       capacity;
    logic       issue_slot;
    logic       req_new;
    logic       resp;
    logic       push;

    // ------------------------------------------------------------------
    // Request / grant / response qualification
    // ------------------------------------------------------------------
    always_comb begin
        pop        = (count_q != 2'd0) & id_ready_i;
        inflight   = (state_q == S_WAIT_RVALID);
        // Entries that will exist once the outstanding response lands; pop
        // only happens with count >= 1, so this never underflows.
        occupancy  = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight};
        capacity   = (occupancy < 3'd2);
        // A new request may start when idle, or back-to-back with the
        // response that retires the current transaction.
        issue_slot = (state_q == S_IDLE) | (inflight & instr_rvalid_i);
        req_new    = issue_slot & fetch_req_i & capacity & ~flush_i;

        // Gated by rst_n so the request reads 0 immediately while in reset,
        // even if the PC keeps fetch_req_i high.
        instr_req_o  = rst_n & ((state_q == S_WAIT_GNT) | req_new);
        instr_addr_o = (state_q == S_WAIT_GNT) ? req_addr_q : fetch_addr_i;

        // discard only ever refers to the transaction stuck in WAIT_GNT; a
        // request issued alongside a discarded response is a fresh one.
        fetch_gnt_o = instr_req_o & instr_gnt_i
                    & ~((state_q == S_WAIT_GNT) & discard_q) & ~flush_i;

        resp = inflight & instr_rvalid_i;
        push = resp & ~discard_q & ~flush_i;
    end

    // ------------------------------------------------------------------
    // Transaction FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        req_addr_d = req_addr_q;
        gnt_addr_d = gnt_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_new) begin
                    if (instr_gnt_i) begin
                        state_d    = S_WAIT_RVALID;
                        gnt_addr_d = fetch_addr_i;
                    end else begin
                        state_d    = S_WAIT_GNT;
                        req_addr_d = fetch_addr_i;
                    end
                end
            end
            S_WAIT_GNT: begin
                discard_d = discard_q | flush_i;
                if (instr_gnt_i) begin
                    state_d    = S_WAIT_RVALID;
                    gnt_addr_d = req_addr_q;
                end
            end
            S_WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    // The outstanding response retires here; any request
                    // issued now is not subject to a prior flush.
                    discard_d = 1'b0;
                    if (req_new) begin
                        if (instr_gnt_i) begin
                            state_d    = S_WAIT_RVALID;
                            gnt_addr_d = fetch_addr_i;
                        end else begin
                            state_d    = S_WAIT_GNT;
                            req_addr_d = fetch_addr_i;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    discard_d = discard_q | flush_i;
                end
            end
            default: begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Two-entry FIFO, entry 0 is always the head
    // ------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        e0_addr_d  = e0_addr_q;
        e0_instr_d = e0_instr_q;
        e1_addr_d  = e1_addr_q;
        e1_instr_d = e1_instr_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_addr_d  = gnt_addr_q;
                        e0_instr_d = instr_rdata_i;
                        count_d    = 2'd1;
                    end else if (count_q == 2'd1) begin
                        e1_addr_d  = gnt_addr_q;
                        e1_instr_d = instr_rdata_i;
                        count_d    = 2'd2;
                    end
                end
                2'b01: begin
                    e0_addr_d  = e1_addr_q;
                    e0_instr_d = e1_instr_q;
                    count_d    = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_addr_d  = gnt_addr_q;
                        e0_instr_d = instr_rdata_i;
                    end else begin
                        e0_addr_d  = e1_addr_q;
                        e0_instr_d = e1_instr_q;
                        e1_addr_d  = gnt_addr_q;
                        e1_instr_d = instr_rdata_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            discard_q  <= 1'b0;
            req_addr_q <= '0;
            gnt_addr_q <= '0;
            count_q    <= 2'd0;
            e0_addr_q  <= '0;
            e0_instr_q <= '0;
            e1_addr_q  <= '0;
            e1_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            req_addr_q <= req_addr_d;
            gnt_addr_q <= gnt_addr_d;
            count_q    <= count_d;
            e0_addr_q  <= e0_addr_d;
            e0_instr_q <= e0_instr_d;
            e1_addr_q  <= e1_addr_d;
            e1_instr_q <= e1_instr_d;
        end
    end

    assign id_valid_o = (count_q != 2'd0);
    assign id_instr_o = e0_instr_q;
    assign id_pc_o    = e0_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Directed self-checking bench for fetch_buffer. An optional
//            auto memory (grant = request, rvalid one cycle later, data =
//            0xA0000000 | address) and auto PC (advances by 4 on fetch_gnt_o)
//            cover streaming; the remaining steps drive memory by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [31:0]   instr_rdata;
    logic          flush = 1'b0;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [AW-1:0] id_pc;
    logic          id_ready = 1'b0;

    // stimulus controls
    logic          mem_auto = 1'b0;
    logic          gnt_man = 1'b0;
    logic          rv_man = 1'b0;
    logic [31:0]   rd_man = '0;
    logic [AW-1:0] addr_man = '0;
    logic          pc_set = 1'b0;
    logic [AW-1:0] pc_val = '0;

    // auto memory / PC state
    logic          rv_auto;
    logic [31:0]   rd_auto;
    logic [AW-1:0] pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign instr_gnt    = mem_auto ? instr_req : gnt_man;
    assign instr_rvalid = mem_auto ? rv_auto : rv_man;
    assign instr_rdata  = mem_auto ? rd_auto : rd_man;
    assign fetch_addr   = mem_auto ? pc : addr_man;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_auto <= 1'b0;
            rd_auto <= '0;
        end else begin
            rv_auto <= mem_auto & instr_req & instr_gnt;
            rd_auto <= 32'hA000_0000 | {22'd0, instr_addr};
        end
    end

    always @(posedge clk) begin
        if (pc_set)         pc <= pc_val;
        else if (fetch_gnt) pc <= pc + 10'd4;
    end

    fetch_buffer #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_gnt_o   (fetch_gnt),
        .instr_req_o   (instr_req),
        .instr_addr_o  (instr_addr),
        .instr_gnt_i   (instr_gnt),
        .instr_rvalid_i(instr_rvalid),
        .instr_rdata_i (instr_rdata),
        .flush_i       (flush),
        .id_valid_o    (id_valid),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .id_ready_i    (id_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hold reset for two edges, release 1 ns after an edge
    task automatic do_reset();
        rst_n  = 1'b0;
        pc_set = 1'b1;
        pc_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pc_set = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_req",   {31'd0, instr_req}, 32'd0);
        chk("rst_gnt",   {31'd0, fetch_gnt}, 32'd0);
        chk("rst_valid", {31'd0, id_valid},  32'd0);

        // ---------------- streaming: 0x000, 0x004, 0x008 ----------------
        mem_auto = 1'b1; id_ready = 1'b1; fetch_req = 1'b1;
        do_reset();
        chk("s1_gnt0",  {31'd0, fetch_gnt}, 32'd1);
        chk("s1_addr0", {22'd0, instr_addr}, 32'h000);
        step();
        chk("s1_nobypass", {31'd0, id_valid}, 32'd0);
        chk("s1_addr1", {22'd0, instr_addr}, 32'h004);
        step();
        chk("s1_valid0", {31'd0, id_valid}, 32'd1);
        chk("s1_pc0",    {22'd0, id_pc},    32'h000);
        chk("s1_ins0",   id_instr,          32'hA000_0000);
        step();
        chk("s1_pc1",    {22'd0, id_pc},    32'h004);
        chk("s1_ins1",   id_instr,          32'hA000_0004);
        step();
        chk("s1_pc2",    {22'd0, id_pc},    32'h008);
        chk("s1_ins2",   id_instr,          32'hA000_0008);

        // ---------------- back-pressure: fills exactly 2 ----------------
        id_ready = 1'b0;
        do_reset();
        step();
        step();
        chk("s2_pc_a",  {22'd0, id_pc},     32'h000);
        step();
        chk("s2_full_req0", {31'd0, instr_req}, 32'd0);
        step();
        chk("s2_full_req1", {31'd0, instr_req}, 32'd0);
        chk("s2_head",  {22'd0, id_pc},     32'h000);
        id_ready = 1'b1;
        #1;
        chk("s2_restart_req",  {31'd0, instr_req}, 32'd1);
        chk("s2_restart_addr", {22'd0, instr_addr}, 32'h008);
        step();
        chk("s2_pc4",   {22'd0, id_pc},    32'h004);
        chk("s2_ins4",  id_instr,          32'hA000_0004);
        step();
        chk("s2_pc8",   {22'd0, id_pc},    32'h008);
        step();
        chk("s2_pc12",  {22'd0, id_pc},    32'h00C);
        chk("s2_ins12", id_instr,          32'hA000_000C);

        // ---------------- grant withheld 3 cycles ----------------
        mem_auto = 1'b0; fetch_req = 1'b1; addr_man = 10'h040; gnt_man = 1'b0;
        do_reset();
        chk("s3_req_c0",  {31'd0, instr_req}, 32'd1);
        chk("s3_addr_c0", {22'd0, instr_addr}, 32'h040);
        chk("s3_gnt_c0",  {31'd0, fetch_gnt}, 32'd0);
        step();
        addr_man = 10'h080; #1;
        chk("s3_addr_c1", {22'd0, instr_addr}, 32'h040);
        chk("s3_gnt_c1",  {31'd0, fetch_gnt}, 32'd0);
        step();
        addr_man = 10'h0C0; #1;
        chk("s3_req_c2",  {31'd0, instr_req}, 32'd1);
        chk("s3_addr_c2", {22'd0, instr_addr}, 32'h040);
        step();
        gnt_man = 1'b1; #1;
        chk("s3_gnt_c3",  {31'd0, fetch_gnt}, 32'd1);
        chk("s3_addr_c3", {22'd0, instr_addr}, 32'h040);
        step();
        gnt_man = 1'b0; fetch_req = 1'b0; #1;
        chk("s3_gnt_c4",  {31'd0, fetch_gnt}, 32'd0);
        chk("s3_req_c4",  {31'd0, instr_req}, 32'd0);
        step();
        rv_man = 1'b1; rd_man = 32'h1111_1111; #1;
        chk("s3_nobypass", {31'd0, id_valid}, 32'd0);
        step();
        rv_man = 1'b0; #1;
        chk("s3_valid", {31'd0, id_valid}, 32'd1);
        chk("s3_pc",    {22'd0, id_pc},    32'h040);
        chk("s3_ins",   id_instr,          32'h1111_1111);

        // ---------------- flush in WAIT_RVALID with 1 buffered ----------------
        id_ready = 1'b0; fetch_req = 1'b1; addr_man = 10'h010; gnt_man = 1'b1;
        do_reset();
        chk("s4_gnt_c0", {31'd0, fetch_gnt}, 32'd1);
        step();
        rv_man = 1'b1; rd_man = 32'h2222_2222; addr_man = 10'h014; #1;
        chk("s4_gnt_c1", {31'd0, fetch_gnt}, 32'd1);
        step();
        rv_man = 1'b0; gnt_man = 1'b0; fetch_req = 1'b0; flush = 1'b1; #1;
        chk("s4_valid_pre", {31'd0, id_valid}, 32'd1);
        chk("s4_req_flush", {31'd0, instr_req}, 32'd0);
        step();
        flush = 1'b0; #1;
        chk("s4_flushed", {31'd0, id_valid}, 32'd0);
        rv_man = 1'b1; rd_man = 32'hDEAD_BEEF; fetch_req = 1'b1; addr_man = 10'h100; gnt_man = 1'b1; #1;
        chk("s4_new_gnt",  {31'd0, fetch_gnt}, 32'd1);
        chk("s4_new_addr", {22'd0, instr_addr}, 32'h100);
        step();
        rv_man = 1'b0; fetch_req = 1'b0; gnt_man = 1'b0; #1;
        chk("s4_dropped", {31'd0, id_valid}, 32'd0);
        step();
        rv_man = 1'b1; rd_man = 32'h3333_3333; #1;
        chk("s4_wait", {31'd0, id_valid}, 32'd0);
        step();
        rv_man = 1'b0; #1;
        chk("s4_valid", {31'd0, id_valid}, 32'd1);
        chk("s4_pc",    {22'd0, id_pc},    32'h100);
        chk("s4_ins",   id_instr,          32'h3333_3333);

        // ---------------- flush with pop and rvalid together ----------------
        fetch_req = 1'b1; addr_man = 10'h104; gnt_man = 1'b1; #1;
        chk("s5_gnt", {31'd0, fetch_gnt}, 32'd1);
        step();
        fetch_req = 1'b0; gnt_man = 1'b0; id_ready = 1'b1;
        rv_man = 1'b1; rd_man = 32'h4444_4444; flush = 1'b1; #1;
        chk("s5_valid_pre", {31'd0, id_valid}, 32'd1);
        step();
        flush = 1'b0; rv_man = 1'b0; id_ready = 1'b0; #1;
        chk("s5_empty0", {31'd0, id_valid}, 32'd0);
        step();
        chk("s5_empty1", {31'd0, id_valid}, 32'd0);
        fetch_req = 1'b1; addr_man = 10'h200; gnt_man = 1'b1; #1;
        chk("s5_idle_gnt", {31'd0, fetch_gnt}, 32'd1);

        // ---------------- reset during WAIT_GNT ----------------
        step();
        gnt_man = 1'b0; addr_man = 10'h300; rv_man = 1'b1; rd_man = 32'h5555_5555; #1;
        chk("s6_req",  {31'd0, instr_req}, 32'd1);
        chk("s6_gnt",  {31'd0, fetch_gnt}, 32'd0);
        step();
        rv_man = 1'b0; #1;
        chk("s6_valid", {31'd0, id_valid}, 32'd1);
        chk("s6_pc",    {22'd0, id_pc},    32'h200);
        chk("s6_wg_addr", {22'd0, instr_addr}, 32'h300);
        #1;
        rst_n = 1'b0; gnt_man = 1'b1; #1;
        chk("s6_rst_req",   {31'd0, instr_req}, 32'd0);
        chk("s6_rst_valid", {31'd0, id_valid},  32'd0);
        chk("s6_rst_gnt",   {31'd0, fetch_gnt}, 32'd0);
        chk("s6_rst_pc",    {22'd0, id_pc},     32'h000);
        chk("s6_rst_ins",   id_instr,           32'h0);
        step();
        rst_n = 1'b1; fetch_req = 1'b0; gnt_man = 1'b0; rv_man = 1'b1; rd_man = 32'h6666_6666; #1;
        step();
        rv_man = 1'b0; #1;
        chk("s6_stray0", {31'd0, id_valid}, 32'd0);
        step();
        chk("s6_stray1", {31'd0, id_valid}, 32'd0);
        chk("s6_idle_req", {31'd0, instr_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, the program-memory byte-address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fetch_req_i  input  1  the program counter requests a fetch.
REQ-005 SHALL have port fetch_addr_i  input  MEM_ADDR_WIDTH  the program counter fetch address.
REQ-006 SHALL have port fetch_gnt_o  output  1  grant back to the program counter; the PC advances on it.
REQ-007 SHALL have port instr_req_o  output  1  program-memory request.
REQ-008 SHALL have port instr_addr_o  output  MEM_ADDR_WIDTH  program-memory address.
REQ-009 SHALL have port instr_gnt_i  input  1  program-memory grant.
REQ-010 SHALL have port instr_rvalid_i  input  1  program-memory read data valid.
REQ-011 SHALL have port instr_rdata_i  input  32  program-memory read data.
REQ-012 SHALL have port flush_i  input  1  taken branch or jump; discard all buffered and in-flight fetches.
REQ-013 SHALL have port id_valid_o  output  1  a buffered instruction is presented to decode.
REQ-014 SHALL have port id_instr_o  output  32  the buffered instruction word.
REQ-015 SHALL have port id_pc_o  output  MEM_ADDR_WIDTH  the address of id_instr_o.
REQ-016 SHALL have port id_ready_i  input  1  decode accepts the presented instruction.

Function
REQ-017 SHALL contain a 2-entry FIFO of {address, instruction} with a count of 0..2; head drives id_pc_o and id_instr_o; id_valid_o = (count != 0).
REQ-018 SHALL pop the FIFO head when id_valid_o and id_ready_i are both 1 on a clock edge.
REQ-019 SHALL implement the states IDLE, WAIT_GNT (request issued, no grant yet) and WAIT_RVALID (granted, one response outstanding); at most one transaction is outstanding.
REQ-020 SHALL define issue capacity as (count - pop + inflight) < 2, where inflight = 1 only in WAIT_RVALID, pop is the REQ-018 pop, and all values are evaluated in the current cycle.
REQ-021 SHALL, in IDLE (or in WAIT_RVALID while instr_rvalid_i = 1), drive instr_req_o = fetch_req_i & capacity & ~flush_i and drive instr_addr_o = fetch_addr_i combinationally.
REQ-022 SHALL latch the address when instr_req_o = 1 and instr_gnt_i = 0, move to WAIT_GNT, and hold instr_req_o = 1 and the latched instr_addr_o stable until the grant.
REQ-023 SHALL move to WAIT_RVALID on instr_req_o & instr_gnt_i, record the granted address, and drive fetch_gnt_o = instr_req_o & instr_gnt_i & ~discard & ~flush_i.
REQ-024 SHALL, on instr_rvalid_i in WAIT_RVALID with discard = 0, push {recorded address, instr_rdata_i}; id_valid_o rises the following cycle, with no combinational bypass.
REQ-025 SHALL, on instr_rvalid_i in WAIT_RVALID, return to IDLE, or go to WAIT_GNT/WAIT_RVALID when REQ-021 issues in the same cycle.
REQ-026 SHALL, on flush_i = 1, empty the FIFO (count = 0) at the edge, overriding any push or pop in that cycle.
REQ-027 SHALL, on flush_i = 1 in WAIT_GNT, keep the request asserted and set discard; the eventual grant produces no fetch_gnt_o.
REQ-028 SHALL, on flush_i = 1 in WAIT_RVALID or in the same cycle as instr_rvalid_i, drop that response without a push; discard clears when the discarded response arrives.
REQ-029 SHALL ignore instr_rvalid_i outside WAIT_RVALID.

Reset
REQ-030 SHALL, when rst_n = 0, immediately force state IDLE, count 0, discard 0, and all latched addresses and data to 0, so that instr_req_o, fetch_gnt_o and id_valid_o read 0.
REQ-031 SHALL, on reset asserted mid-transaction, abandon the outstanding fetch; a late instr_rvalid_i after reset is ignored per REQ-029.

Verification
REQ-032 Bench SHALL run: memory grants immediately and sets rvalid 1 cycle later, id_ready_i = 1, fetches from 0x000 -> id_pc_o shows 0x000, 0x004, 0x008 in order, with each instruction on id_instr_o one cycle after its rvalid.
REQ-033 Bench SHALL run: id_ready_i = 0 -> exactly 2 entries are filled, then instr_req_o stays 0; raising id_ready_i restarts fetching with no loss or duplication.
REQ-034 Bench SHALL run: instr_gnt_i withheld 3 cycles while fetch_addr_i changes -> instr_addr_o stays at the first address, and fetch_gnt_o pulses once, on the grant cycle.
REQ-035 Bench SHALL run: flush_i asserted in WAIT_RVALID with 1 entry buffered -> the next cycle id_valid_o = 0, the pending instr_rdata_i 0xDEADBEEF is never presented, and the next fetch from the new target 0x100 appears normally.
REQ-036 Bench SHALL run: flush_i asserted in the same cycle as a pop and an rvalid -> count = 0 and no entry is pushed.
REQ-037 Bench SHALL run: rst_n dropped during WAIT_GNT -> instr_req_o = 0 and id_valid_o = 0 with no clock edge, and a stray rvalid after release is ignored.
